config_shift_sequencer: RTL and testbench
=========================================

// Module: config_shift_sequencer
// PURPOSE
// Sequences one full write/readback pass of the chip configuration shift register: fetches
// DATA_WIDTH-bit words from a TX buffer, serialises them LSB-first onto ConfigIn under a divided
// ConfigClk, captures ConfigOut into an RX buffer and optionally pulses ConfigLoad at the end.
// Sits between the AXI-lite register/buffer block (start, status, TX/RX RAMs) and the chip pins.
// PARAMETERS
// DATA_WIDTH        32    TX/RX buffer word width
// CONFIG_REG_WIDTH  5164  bits per pass (W)
// CLK_DIVIDER       100   ACLK cycles per ConfigClk half-period (DIV), >=2
// WADDR_WIDTH       8     buffer word address width, >= clog2(ceil(W/DATA_WIDTH))
// PORTS
// S_AXI_ACLK     in   1           sole clock
// S_AXI_ARESETN  in   1           async active-low reset
// start          in   1           1-cycle pulse, begin pass
// abort          in   1           1-cycle pulse, cancel pass
// load_en        in   1           sampled at start; 1 = pulse ConfigLoad after shift
// busy           out  1           pass in progress
// done           out  1           1-cycle pulse, pass completed
// tx_addr        out  WADDR_WIDTH TX buffer word address
// tx_rd          out  1           TX read strobe; tx_data valid the following cycle
// tx_data        in   DATA_WIDTH  TX word
// rx_addr        out  WADDR_WIDTH RX buffer word address
// rx_we          out  1           RX write strobe
// rx_data        out  DATA_WIDTH  RX word
// ConfigClk      out  1           divided shift clock to chip
// ConfigIn       out  1           serial data to chip
// ConfigLoad     out  1           parallel-load strobe to chip
// ConfigOut      in   1           serial data from chip
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0. All outputs registered.
// - States: IDLE -> FETCH -> SHIFT_LO <-> SHIFT_HI -> TAIL -> LOAD (if load_en) -> DONE -> IDLE.
// - IDLE: start accepted at edge E0 -> busy=1, tx_rd=1, tx_addr=0. abort wins over same-cycle start.
// - FETCH: tx_data latched at E2; SHIFT_LO entered, ConfigIn=bit 0 from E2.
// - Bit k = tx word k/DATA_WIDTH, bit k%DATA_WIDTH; order k=0..W-1.
// - SHIFT_LO: ConfigClk=0 for DIV cycles, ConfigIn stable. SHIFT_HI: ConfigClk=1 for DIV cycles.
//   ConfigIn changes only on the cycle ConfigClk falls (setup = DIV cycles).
// - ConfigOut sampled on the ACLK edge where ConfigClk goes 0->1; captured bit k -> rx bit k.
// - Prefetch: tx_rd pulses on first SHIFT_HI cycle of a word's last bit, addr+1; the word is
//   latched on the next cycle and is not used before the next SHIFT_LO. No tx_rd past last word.
// - rx_we pulses 1 cycle after the capture of a word's last bit or bit W-1. Unused upper bits of
//   the final word are 0. rx_addr = word index.
// - TAIL: ConfigClk=0, ConfigIn=0, DIV cycles. LOAD: ConfigLoad=1 for DIV cycles.
// - DONE: done=1 and busy=0 for one cycle; then IDLE.
// - busy duration = 2 + 2*DIV*W + DIV + (load_en ? DIV : 0) cycles.
// - start while busy: ignored. load_en is sampled only at accept.
// - abort while busy: next cycle IDLE, busy=0, ConfigClk/ConfigIn/ConfigLoad=0, no done, no
//   further rx_we; partial RX contents undefined. abort in IDLE: no effect.
// - Async reset mid-pass: identical to reset values; chip state undefined, SW reruns pass.
// - Bit/word counters are sized for W-1 and the word count; no wrap within a pass.
// CONFIGURATION
// CONFIG_READBACK_EN defined: ConfigOut capture and RX port active as above.
// Not defined: capture logic removed; rx_we, rx_addr and rx_data held 0; ConfigOut unused;
// all other timing is unchanged.
// TESTING (W=40, DATA_WIDTH=32, DIV=2, CONFIG_READBACK_EN defined unless noted)
// 1 Reset asserted mid-run -> all outputs 0 asynchronously; FSM IDLE after release.
// 2 TX={0x89ABCDEF,0x000000A5}, load_en=1, start -> 40 ConfigClk rises, ConfigIn LSB-first
//   1,1,1,1,0,1,1,1..., ConfigLoad high 2 cycles, busy 166 cycles, single done pulse.
// 3 Chip model: 40-bit SR preloaded 0x123456789A, ConfigOut=SR[0] -> rx_we x2:
//   0x3456789A@0, 0x00000012@1.
// 4 abort on 10th ConfigClk rise -> ConfigClk=0 next cycle, busy=0, no done, no ConfigLoad;
//   a following start completes a full pass.
// 5 load_en=0 -> no ConfigLoad, busy 164 cycles; start during busy ignored; start+abort in
//   IDLE -> stays IDLE.
// 6 CONFIG_READBACK_EN undefined, scenario 3 -> rx_we never 1; ConfigIn/ConfigClk identical to 2.

Source files
------------

// File: rtl/config_shift_sequencer.sv
// rtl/config_shift_sequencer.sv - one write/readback pass of the chip configuration shift register
// Define CONFIG_READBACK_EN to enable ConfigOut capture into the RX buffer.
module config_shift_sequencer #(
  parameter int DATA_WIDTH       = 32,
  parameter int CONFIG_REG_WIDTH = 5164,
  parameter int CLK_DIVIDER      = 100,
  parameter int WADDR_WIDTH      = 8
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   load_en,
  output logic                   busy,
  output logic                   done,
  output logic [WADDR_WIDTH-1:0] tx_addr,
  output logic                   tx_rd,
  input  logic [DATA_WIDTH-1:0]  tx_data,
  output logic [WADDR_WIDTH-1:0] rx_addr,
  output logic                   rx_we,
  output logic [DATA_WIDTH-1:0]  rx_data,
  output logic                   ConfigClk,
  output logic                   ConfigIn,
  output logic                   ConfigLoad,
  input  logic                   ConfigOut
);
  localparam int BW = (CONFIG_REG_WIDTH > 1) ? $clog2(CONFIG_REG_WIDTH) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int CW = $clog2(CLK_DIVIDER);
  localparam logic [BW-1:0] LAST_BIT = BW'(CONFIG_REG_WIDTH - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] LAST_DIV = CW'(CLK_DIVIDER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SHIFT_LO, S_SHIFT_HI, S_TAIL, S_LOAD, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          div_q, div_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [DATA_WIDTH-1:0]  tx_sr_q, tx_sr_d;
  logic [WADDR_WIDTH-1:0] tx_addr_q, tx_addr_d;
  logic                   load_q, load_d;
  logic                   rd_dly_q;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   tx_rd_q, tx_rd_d;
  logic                   cclk_q, cclk_d;
  logic                   cin_q, cin_d;
  logic                   cload_q, cload_d;

  logic                   div_end, last_bit, word_end;
  logic [DATA_WIDTH-1:0]  tx_word, tx_shift;

  assign div_end  = (div_q == LAST_DIV);
  assign last_bit = (bit_q == LAST_BIT);
  assign word_end = (idx_q == LAST_IDX);
  // tx_data is valid the cycle after a tx_rd strobe; forward it so a word
  // arriving on the last SHIFT_HI cycle is usable at the same edge.
  assign tx_word  = rd_dly_q ? tx_data : tx_sr_q;
  assign tx_shift = tx_sr_q >> 1;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      idx_q     <= '0;
      tx_sr_q   <= '0;
      tx_addr_q <= '0;
      load_q    <= 1'b0;
      rd_dly_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_rd_q   <= 1'b0;
      cclk_q    <= 1'b0;
      cin_q     <= 1'b0;
      cload_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      idx_q     <= idx_d;
      tx_sr_q   <= tx_sr_d;
      tx_addr_q <= tx_addr_d;
      load_q    <= load_d;
      rd_dly_q  <= tx_rd_q;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_rd_q   <= tx_rd_d;
      cclk_q    <= cclk_d;
      cin_q     <= cin_d;
      cload_q   <= cload_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start && !abort) state_d = S_FETCH;
      S_FETCH:    if (div_q != '0) state_d = S_SHIFT_LO;
      S_SHIFT_LO: if (div_end) state_d = S_SHIFT_HI;
      S_SHIFT_HI: if (div_end) state_d = last_bit ? S_TAIL : S_SHIFT_LO;
      S_TAIL:     if (div_end) state_d = load_q ? S_LOAD : S_DONE;
      S_LOAD:     if (div_end) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    div_d     = (state_d != state_q || state_q == S_IDLE) ? '0 : div_q + 1'b1;
    bit_d     = bit_q;
    idx_d     = idx_q;
    tx_sr_d   = tx_word;
    tx_addr_d = tx_addr_q;
    load_d    = load_q;
    tx_rd_d   = 1'b0;
    cin_d     = cin_q;
    busy_d    = state_d inside {S_FETCH, S_SHIFT_LO, S_SHIFT_HI, S_TAIL, S_LOAD};
    done_d    = (state_d == S_DONE);
    cclk_d    = (state_d == S_SHIFT_HI);
    cload_d   = (state_d == S_LOAD);
    if (state_q == S_IDLE && state_d == S_FETCH) begin
      tx_rd_d   = 1'b1;
      tx_addr_d = '0;
      load_d    = load_en;
      bit_d     = '0;
      idx_d     = '0;
    end
    if (state_q == S_FETCH && state_d == S_SHIFT_LO) cin_d = tx_word[0];
    if (state_q == S_SHIFT_LO && state_d == S_SHIFT_HI && word_end && !last_bit) begin
      tx_rd_d   = 1'b1;
      tx_addr_d = tx_addr_q + 1'b1;
    end
    if (state_q == S_SHIFT_HI && state_d == S_SHIFT_LO) begin
      bit_d = bit_q + 1'b1;
      if (word_end) begin
        idx_d = '0;
        cin_d = tx_word[0];
      end else begin
        idx_d   = idx_q + 1'b1;
        tx_sr_d = tx_shift;
        cin_d   = tx_shift[0];
      end
    end
    if (!(state_d inside {S_SHIFT_LO, S_SHIFT_HI})) cin_d = 1'b0;
    if (state_d == S_IDLE) tx_addr_d = '0;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign tx_rd      = tx_rd_q;
  assign tx_addr    = tx_addr_q;
  assign ConfigClk  = cclk_q;
  assign ConfigIn   = cin_q;
  assign ConfigLoad = cload_q;

`ifdef CONFIG_READBACK_EN
  logic [DATA_WIDTH-1:0]  rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0]  rx_data_q, rx_data_d;
  logic [WADDR_WIDTH-1:0] rx_addr_q, rx_addr_d;
  logic                   rx_we_q, rx_we_d;
  logic                   capture;

  // ConfigOut is sampled on the edge that raises ConfigClk; tx_addr_q still
  // holds the index of the word being captured at that edge.
  assign capture = (state_q == S_SHIFT_LO && state_d == S_SHIFT_HI);

  always_comb begin
    rx_sr_d   = rx_sr_q;
    rx_we_d   = 1'b0;
    rx_addr_d = rx_addr_q;
    rx_data_d = rx_data_q;
    if (capture) begin
      if (idx_q == '0) rx_sr_d = '0;
      rx_sr_d[idx_q] = ConfigOut;
      if (word_end || last_bit) begin
        rx_we_d   = 1'b1;
        rx_addr_d = tx_addr_q;
        rx_data_d = rx_sr_d;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      rx_addr_q <= '0;
      rx_we_q   <= 1'b0;
    end else begin
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      rx_addr_q <= rx_addr_d;
      rx_we_q   <= rx_we_d;
    end
  end

  assign rx_we   = rx_we_q;
  assign rx_addr = rx_addr_q;
  assign rx_data = rx_data_q;
`else
  logic unused_config_out;
  assign unused_config_out = ConfigOut;
  assign rx_we   = 1'b0;
  assign rx_addr = '0;
  assign rx_data = '0;
`endif

endmodule

// File: tb/tb_config_shift_sequencer.sv
// tb/tb_config_shift_sequencer.sv - scoreboard bench for config_shift_sequencer
module tb_config_shift_sequencer;
  localparam int DW  = 32;
  localparam int W   = 40;
  localparam int DIV = 2;
  localparam int AW  = 8;
`ifdef CONFIG_READBACK_EN
  localparam int EXP_RX = 2;
`else
  localparam int EXP_RX = 0;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, load_en = 1'b0;
  logic          busy, done, tx_rd, rx_we;
  logic [AW-1:0] tx_addr, rx_addr;
  logic [DW-1:0] tx_data = '0;
  logic [DW-1:0] rx_data;
  logic          ConfigClk, ConfigIn, ConfigLoad, ConfigOut;

  always #5 clk = ~clk;

  config_shift_sequencer #(
    .DATA_WIDTH(DW), .CONFIG_REG_WIDTH(W), .CLK_DIVIDER(DIV), .WADDR_WIDTH(AW)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
    .load_en(load_en), .busy(busy), .done(done), .tx_addr(tx_addr), .tx_rd(tx_rd),
    .tx_data(tx_data), .rx_addr(rx_addr), .rx_we(rx_we), .rx_data(rx_data),
    .ConfigClk(ConfigClk), .ConfigIn(ConfigIn), .ConfigLoad(ConfigLoad),
    .ConfigOut(ConfigOut)
  );

  // TX buffer: registered read, data valid the cycle after tx_rd
  logic [DW-1:0] tx_mem [0:(1<<AW)-1];
  always @(posedge clk) if (tx_rd) tx_data <= tx_mem[tx_addr];

  // Chip model: shift register clocked by ConfigClk, LSB drives ConfigOut
  logic [W-1:0] chip_sr = '0, chip_pre = '0;
  logic         chip_ld = 1'b0;
  always @(posedge ConfigClk or posedge chip_ld)
    if (chip_ld) chip_sr <= chip_pre;
    else         chip_sr <= {ConfigIn, chip_sr[W-1:1]};
  assign ConfigOut = chip_sr[0];

  logic [54:0] outs;
  assign outs = {busy, done, tx_rd, tx_addr, rx_we, rx_addr, rx_data,
                 ConfigClk, ConfigIn, ConfigLoad};

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic exp_bits[$];
`ifdef CONFIG_READBACK_EN
  logic [AW+DW-1:0] exp_rx[$];
`endif

  int   rises = 0, busy_cyc = 0, load_cyc = 0, done_cnt = 0, txrd_cnt = 0, rx_cnt = 0;
  int   viol = 0, hi_len = 0;
  logic prev_cclk = 1'b0, prev_cin = 1'b0;

  always @(negedge clk) begin : mon
    logic             b;
    logic [AW+DW-1:0] e;
    if (ConfigClk && !prev_cclk) begin
      rises <= rises + 1;
      if (exp_bits.size() == 0) chk("extra_rise", 1, 0);
      else begin
        b = exp_bits.pop_front();
        chk("config_in", ConfigIn, b);
      end
    end
    if (ConfigClk && ConfigIn !== prev_cin) viol <= viol + 1;
    if (ConfigClk) hi_len <= hi_len + 1;
    else begin
      if (prev_cclk && hi_len != DIV) viol <= viol + 1;
      hi_len <= 0;
    end
    if (busy)       busy_cyc <= busy_cyc + 1;
    if (ConfigLoad) load_cyc <= load_cyc + 1;
    if (done)       done_cnt <= done_cnt + 1;
    if (tx_rd)      txrd_cnt <= txrd_cnt + 1;
    if (rx_we)      rx_cnt   <= rx_cnt + 1;
`ifdef CONFIG_READBACK_EN
    if (rx_we) begin
      if (exp_rx.size() == 0) chk("rx_extra", 1, 0);
      else begin
        e = exp_rx.pop_front();
        chk("rx_word", {rx_addr, rx_data}, e);
      end
    end
`else
    e = '0;
    if (rx_we || rx_addr != '0 || rx_data != '0) chk("rx_off", {rx_we, rx_addr, rx_data}, e);
`endif
    prev_cclk <= ConfigClk;
    prev_cin  <= ConfigIn;
  end

  task automatic prime(input logic [DW-1:0] w0, input logic [DW-1:0] w1, input logic [W-1:0] pre);
    logic [2*DW-1:0] words;
    logic [DW-1:0]   hi;
    @(negedge clk);
    tx_mem[0] = w0;
    tx_mem[1] = w1;
    words = {w1, w0};
    for (int k = 0; k < W; k++) exp_bits.push_back(words[k]);
    hi = '0;
    hi[W-DW-1:0] = pre[W-1:DW];
`ifdef CONFIG_READBACK_EN
    exp_rx.push_back({AW'(0), pre[DW-1:0]});
    exp_rx.push_back({AW'(1), hi});
`endif
    chip_pre = pre;
    chip_ld  = 1'b1;
    #1 chip_ld = 1'b0;
  endtask

  task automatic pulse_start(input logic le);
    load_en = le;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    load_en = ~le;
  endtask

  task automatic run_pass(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [W-1:0] pre, input logic le, input logic poke);
    int b_rise, b_busy, b_done, b_load, b_rd, b_rx, b_viol, cyc;
    logic seen;
    logic [2*DW-1:0] words;
    words = {w1, w0};
    prime(w0, w1, pre);
    b_rise = rises; b_busy = busy_cyc; b_done = done_cnt; b_load = load_cyc;
    b_rd = txrd_cnt; b_rx = rx_cnt; b_viol = viol;
    pulse_start(le);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = poke && (cyc == 40);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    chk("done_seen", seen, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("busy_len", busy_cyc - b_busy, 2 + 2*DIV*W + DIV + (le ? DIV : 0));
    chk("load_len", load_cyc - b_load, le ? DIV : 0);
    chk("done_cnt", done_cnt - b_done, 1);
    chk("rises", rises - b_rise, W);
    chk("tx_rd_cnt", txrd_cnt - b_rd, 2);
    chk("rx_we_cnt", rx_cnt - b_rx, EXP_RX);
    chk("timing_viol", viol - b_viol, 0);
    chk("bits_left", exp_bits.size(), 0);
    chk("chip_sr", chip_sr, words[W-1:0]);
`ifdef CONFIG_READBACK_EN
    chk("rx_left", exp_rx.size(), 0);
`endif
  endtask

  initial begin
    int b_rise, b_busy, b_done, b_load, b_rd, b_rx, cyc;
    logic [W-1:0] rpre;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // asynchronous reset in the middle of a pass
    prime(32'h89ABCDEF, 32'h000000A5, 40'h123456789A);
    b_rise = rises;
    pulse_start(1'b1);
    cyc = 0;
    while (rises - b_rise < 3 && cyc < 200) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("reset_wait", rises - b_rise, 3);
    chk("pre_reset_cclk", ConfigClk, 1);
    #1 rst_n = 1'b0;
    #1 chk("async_reset", outs, 0);
    @(negedge clk);
    exp_bits.delete();
`ifdef CONFIG_READBACK_EN
    exp_rx.delete();
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_reset_idle", {busy, ConfigClk, tx_rd, ConfigLoad}, 0);

    run_pass(32'h89ABCDEF, 32'h000000A5, 40'h123456789A, 1'b1, 1'b0);

    // abort on the 10th ConfigClk rise
    rpre = {8'($urandom), 32'($urandom)};
    prime($urandom, $urandom, rpre);
    b_rise = rises;
    b_rx   = rx_cnt;
    pulse_start(1'b1);
    cyc = 0;
    while (rises - b_rise < 10 && cyc < 400) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    chk("abort_wait", rises - b_rise, 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cclk", ConfigClk, 0);
    chk("abort_busy", busy, 0);
    #1;
    b_done = done_cnt; b_load = load_cyc; b_busy = busy_cyc;
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_done", done_cnt - b_done, 0);
    chk("abort_no_load", load_cyc - b_load, 0);
    chk("abort_idle", busy_cyc - b_busy, 0);
    chk("abort_no_rx", rx_cnt - b_rx, 0);
    chk("abort_bits_left", exp_bits.size(), W - 10);
    exp_bits.delete();
`ifdef CONFIG_READBACK_EN
    exp_rx.delete();
`endif

    rpre = {8'($urandom), 32'($urandom)};
    run_pass($urandom, $urandom, rpre, 1'b1, 1'b0);

    // no load, and a start pulse mid-pass that must be ignored
    run_pass(32'hFFFF0000, 32'h0000005A, 40'hA50F0FF0F0, 1'b0, 1'b1);

    // start and abort together in IDLE
    @(negedge clk);
    #1;
    b_rd = txrd_cnt; b_busy = busy_cyc;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_abort_busy", busy_cyc - b_busy, 0);
    chk("idle_abort_rd", txrd_cnt - b_rd, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
